if_stage_fetchq: RTL
====================

// Module: if_stage_fetchq
// PURPOSE
//  Parametrised fetch stage with a decoupled instruction-buffer front end. Replaces the fixed-latency
//  SRAM fetch with a req/addr_ok/data_ok bus, so several fetches can be in flight while an in-order
//  IBUF absorbs decode back-pressure. Sits between the inst bus and the decode stage, and squashes
//  wrong-path fetches on a branch redirect.
// PARAMETERS
//  RESET_PC    32'h1C000000  first fetch address after reset
//  IBUF_DEPTH  4             instruction buffer entries; power of 2, >=2
//  MAX_OUTST   2             max accepted-but-unreturned requests; 1..IBUF_DEPTH
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high reset
//  ds_allowin      in   1   decode accepts the head entry this cycle
//  br_bus          in   33  {br_taken, br_target[31:0]}: redirect request
//  fs_to_ds_valid  out  1   head IBUF entry valid toward decode
//  fs_to_ds_bus    out  64  {inst[31:0], pc[31:0]} of the head entry
//  inst_req        out  1   fetch request valid
//  inst_addr       out  32  fetch address (= fetch_pc)
//  inst_addr_ok    in   1   request accepted; handshake = inst_req && inst_addr_ok
//  inst_data_ok    in   1   one response this cycle, returned in request order
//  inst_rdata      in   32  response data, valid with inst_data_ok
// BEHAVIOUR
//  State
//  - fetch_pc: 32b
//  - outst_cnt, discard_cnt: clog2(MAX_OUTST+1) bits each
//  - pc-tag FIFO: depth MAX_OUTST
//  - IBUF: IBUF_DEPTH x 64b, with rd/wr pointers and a count
//  Reset
//  - fetch_pc=RESET_PC; all counts and pointers 0; FIFOs empty.
//  - inst_req=0 and fs_to_ds_valid=0 while reset is high.
//  - Reset mid-operation drops all in-flight state. The bus slave shares this reset, so no stale
//    data_ok arrives after reset.
//  Issue
//  - inst_req = !reset && !br_taken && outst_cnt<MAX_OUTST && (outst_cnt+ibuf_cnt)<IBUF_DEPTH.
//  - The credit rule makes every accepted request fit in the IBUF, so the IBUF never overflows.
//  - inst_addr = fetch_pc; stays stable until the handshake or a redirect.
//  - On handshake: fetch_pc += 4 (mod 2^32), push fetch_pc into the tag FIFO, outst_cnt++.
//  Response (data_ok)
//  - Pop the tag FIFO and decrement outst_cnt.
//  - If discard_cnt>0: decrement discard_cnt and drop the data.
//  - Otherwise: push {inst_rdata, tag} into the IBUF.
//  - A handshake and a data_ok in the same cycle leave outst_cnt unchanged.
//  Output
//  - fs_to_ds_valid = ibuf_cnt!=0 && !br_taken; fs_to_ds_bus = IBUF head (registered, no bypass).
//  - Minimum latency data_ok -> fs_to_ds_valid is 1 cycle.
//  - Pop the head when fs_to_ds_valid && ds_allowin.
//  - A push and a pop in the same cycle keep ibuf_cnt unchanged, including when the IBUF is full.
//  Redirect (br_taken=1), all in the same cycle
//  - inst_req forced to 0, so no handshake occurs; fs_to_ds_valid forced to 0.
//  - fetch_pc <= br_target; IBUF flushed (count and pointers to 0).
//  - discard_cnt <= outst_cnt - inst_data_ok: every remaining in-flight request becomes a discard.
//  - A data_ok arriving in the redirect cycle is dropped.
//  - Back-to-back redirects: the last target wins; discard_cnt is recomputed each time.
//  - br_target is not alignment-checked; fetch_pc takes it as given.
// TESTING
//  1. Release reset; slave addr_ok=1, data_ok 1 cycle later; ds_allowin=1
//     -> first addr 0x1C000000, pcs +4 each, one inst per cycle steady state.
//  2. Hold ds_allowin=0 for 10 cycles -> IBUF fills to 4 then inst_req=0, no entry lost;
//     on release, pcs are delivered in order.
//  3. 2 outstanding, br_taken with target 0x1C000100 -> next 2 data_ok dropped;
//     first delivered pc 0x1C000100.
//  4. Redirect in the same cycle as data_ok, IBUF holding 3 entries -> all dropped,
//     fs_to_ds_valid=0 that cycle, discard_cnt=outst_cnt-1.
//  5. addr_ok=0 for 5 cycles -> inst_addr stable, fetch_pc unchanged, outst_cnt unchanged.
//  6. Assert reset mid-stream -> next cycle all counts 0 and fs_to_ds_valid=0;
//     first request after release is to 0x1C000000.

Source files
------------

// File: rtl/if_stage_fetchq.sv
// Fetch stage with a decoupled req/addr_ok/data_ok inst bus and an in-order instruction buffer.
// Redirects flush the buffer and turn every in-flight request into a discard.
module if_stage_fetchq #(
  parameter logic [31:0] RESET_PC   = 32'h1C000000,
  parameter int          IBUF_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int IW = $clog2(IBUF_DEPTH + 1);

  logic        br_taken;
  logic [31:0] br_target;
  assign {br_taken, br_target} = br_bus;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outst_cnt;
  logic [CW-1:0] discard_cnt;

  logic [31:0]   tag_mem [MAX_OUTST];
  logic [TW-1:0] tag_wr;
  logic [TW-1:0] tag_rd;

  logic [63:0]   ibuf [IBUF_DEPTH];
  logic [PW-1:0] ibuf_wr;
  logic [PW-1:0] ibuf_rd;
  logic [IW-1:0] ibuf_cnt;

  logic has_credit;
  logic addr_hs;
  logic ibuf_push;
  logic ibuf_pop;

  // Credits count buffered plus in-flight entries so every accepted request has a slot.
  assign has_credit = (outst_cnt < CW'(MAX_OUTST)) &&
                      ((32'(outst_cnt) + 32'(ibuf_cnt)) < 32'(IBUF_DEPTH));
  assign inst_req   = !reset && !br_taken && has_credit;
  assign inst_addr  = fetch_pc;
  assign addr_hs    = inst_req && inst_addr_ok;

  assign ibuf_push      = !reset && inst_data_ok && !br_taken && (discard_cnt == '0);
  assign fs_to_ds_valid = !reset && !br_taken && (ibuf_cnt != '0);
  assign ibuf_pop       = fs_to_ds_valid && ds_allowin;
  assign fs_to_ds_bus   = ibuf[ibuf_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outst_cnt   <= '0;
      discard_cnt <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      ibuf_wr     <= '0;
      ibuf_rd     <= '0;
      ibuf_cnt    <= '0;
    end else begin
      if (br_taken) begin
        fetch_pc <= br_target;
      end else if (addr_hs) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (addr_hs) begin
        tag_wr <= (tag_wr == TW'(MAX_OUTST - 1)) ? '0 : tag_wr + TW'(1);
      end
      // Tags of squashed requests are still popped as their responses drain.
      if (inst_data_ok) begin
        tag_rd <= (tag_rd == TW'(MAX_OUTST - 1)) ? '0 : tag_rd + TW'(1);
      end

      if (addr_hs && !inst_data_ok) begin
        outst_cnt <= outst_cnt + CW'(1);
      end else if (!addr_hs && inst_data_ok) begin
        outst_cnt <= outst_cnt - CW'(1);
      end

      if (br_taken) begin
        discard_cnt <= outst_cnt - CW'(inst_data_ok);
      end else if (inst_data_ok && (discard_cnt != '0)) begin
        discard_cnt <= discard_cnt - CW'(1);
      end

      if (br_taken) begin
        ibuf_wr  <= '0;
        ibuf_rd  <= '0;
        ibuf_cnt <= '0;
      end else begin
        if (ibuf_push) begin
          ibuf_wr <= ibuf_wr + PW'(1);
        end
        if (ibuf_pop) begin
          ibuf_rd <= ibuf_rd + PW'(1);
        end
        if (ibuf_push && !ibuf_pop) begin
          ibuf_cnt <= ibuf_cnt + IW'(1);
        end else if (!ibuf_push && ibuf_pop) begin
          ibuf_cnt <= ibuf_cnt - IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (addr_hs) begin
      tag_mem[tag_wr] <= fetch_pc;
    end
    if (ibuf_push) begin
      ibuf[ibuf_wr] <= {inst_rdata, tag_mem[tag_rd]};
    end
  end

endmodule
